// File: rtl/booth_operand_feeder.sv
// Sequencer for the 16-bit sequential Booth multiplier: loads operands over the shared
// data bus, waits for done (with a watchdog), and returns the product over valid/ready.
module booth_operand_feeder #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    output logic               mul_start,
    output logic [WIDTH-1:0]   mul_data,
    input  logic               mul_done,
    input  logic [2*WIDTH-1:0] mul_product,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_product,
    output logic               out_timeout,
    output logic               busy
);
    localparam int unsigned CntW = $clog2(TIMEOUT) + 1;

    typedef enum logic [2:0] {StIdle, StLoadM, StHoldM, StWait, StResult} state_e;

    state_e               state_q, state_d;
    logic                 hold_valid_q, hold_valid_d;
    logic [WIDTH-1:0]     hold_a_q, hold_a_d, hold_b_q, hold_b_d;
    logic [WIDTH-1:0]     opa_q, opa_d, opb_q, opb_d;
    logic                 done_q, done_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
    logic                 timeout_q, timeout_d;
    logic                 consume;
    logic                 done_edge;

    assign done_edge = mul_done & ~done_q;

    always_comb begin
        state_d      = state_q;
        hold_valid_d = hold_valid_q;
        hold_a_d     = hold_a_q;
        hold_b_d     = hold_b_q;
        opa_d        = opa_q;
        opb_d        = opb_q;
        done_d       = mul_done;
        cnt_d        = cnt_q;
        product_d    = product_q;
        timeout_d    = timeout_q;
        consume      = 1'b0;

        // No same-cycle bypass: a pair accepted now is consumed on a later cycle.
        if (in_valid && !hold_valid_q) begin
            hold_a_d     = in_a;
            hold_b_d     = in_b;
            hold_valid_d = 1'b1;
        end

        case (state_q)
            StIdle:  consume = hold_valid_q;
            StLoadM: state_d = StHoldM;
            StHoldM: begin
                state_d = StWait;
                cnt_d   = '0;
            end
            StWait: begin
                cnt_d = cnt_q + 1'b1;
                // A done edge wins over a simultaneous watchdog expiry.
                if (done_edge) begin
                    product_d = mul_product;
                    timeout_d = 1'b0;
                    state_d   = StResult;
                end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
                    product_d = '0;
                    timeout_d = 1'b1;
                    state_d   = StResult;
                end
            end
            StResult: begin
                if (out_ready) begin
                    if (hold_valid_q) consume = 1'b1;
                    else              state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (consume) begin
            opa_d        = hold_a_q;
            opb_d        = hold_b_q;
            hold_valid_d = 1'b0;
            state_d      = StLoadM;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            hold_valid_q <= 1'b0;
            hold_a_q     <= '0;
            hold_b_q     <= '0;
            opa_q        <= '0;
            opb_q        <= '0;
            done_q       <= 1'b0;
            cnt_q        <= '0;
            product_q    <= '0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_valid_q <= hold_valid_d;
            hold_a_q     <= hold_a_d;
            hold_b_q     <= hold_b_d;
            opa_q        <= opa_d;
            opb_q        <= opb_d;
            done_q       <= done_d;
            cnt_q        <= cnt_d;
            product_q    <= product_d;
            timeout_q    <= timeout_d;
        end
    end

    always_comb begin
        mul_start = 1'b0;
        mul_data  = '0;
        case (state_q)
            StLoadM: begin
                mul_start = 1'b1;
                mul_data  = opa_q;
            end
            StHoldM: mul_data = opa_q;
            StWait:  mul_data = opb_q;
            default: mul_data = '0;
        endcase
    end

    assign in_ready    = ~hold_valid_q;
    assign out_valid   = (state_q == StResult);
    assign out_product = product_q;
    assign out_timeout = timeout_q;
    assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_booth_operand_feeder.sv
// Directed bench for booth_operand_feeder with a small behavioural Booth multiplier model.
module tb_booth_operand_feeder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_a = '0;
    logic [15:0] in_b = '0;
    logic        mul_start;
    logic [15:0] mul_data;
    logic        mul_done;
    logic [31:0] mul_product;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_product;
    logic        out_timeout;
    logic        busy;

    int passed = 0;
    int total  = 0;

    // Model knobs: never raise done, and how many cycles after start done drops.
    logic never_done = 1'b0;
    int   drop_delay = 1;
    localparam int Lat = 6;

    booth_operand_feeder #(.WIDTH(16), .TIMEOUT(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .mul_start   (mul_start),
        .mul_data    (mul_data),
        .mul_done    (mul_done),
        .mul_product (mul_product),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_product (out_product),
        .out_timeout (out_timeout),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Multiplier model: latches A on start, B two cycles later; done stays high until
    // drop_delay cycles after the next start.
    logic signed [15:0] m_a, m_b;
    int ph;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_done    <= 1'b0;
            mul_product <= '0;
            ph          <= 0;
            m_a         <= '0;
            m_b         <= '0;
        end else if (mul_start) begin
            m_a <= mul_data;
            ph  <= 1;
        end else if (ph != 0) begin
            ph <= ph + 1;
            if (ph == drop_delay) mul_done <= 1'b0;
            if (ph == 2) m_b <= mul_data;
            if (ph == Lat) begin
                ph <= 0;
                if (!never_done) begin
                    mul_done    <= 1'b1;
                    mul_product <= 32'(m_a * m_b);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] b);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!out_valid && n < 30) begin
            tick();
            n++;
        end
        check(tag, 32'(out_valid), 32'd1);
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        int n;
        logic [31:0] held;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_mul_start", 32'(mul_start), 32'd0);
        check("rst_mul_data", 32'(mul_data), 32'd0);
        check("rst_out_product", out_product, 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // Single operation 3 * -4.
        send(16'd3, 16'hFFFC);
        check("t1_in_ready_held", 32'(in_ready), 32'd0);
        check("t1_no_start_idle", 32'(mul_start), 32'd0);
        tick();
        check("t1_start", 32'(mul_start), 32'd1);
        check("t1_data_a0", 32'(mul_data), 32'd3);
        tick();
        check("t1_start_low", 32'(mul_start), 32'd0);
        check("t1_data_a1", 32'(mul_data), 32'd3);
        tick();
        check("t1_data_b", 32'(mul_data), 32'h0000FFFC);
        wait_valid("t1_valid");
        check("t1_product", out_product, 32'hFFFFFFF4);
        check("t1_timeout", 32'(out_timeout), 32'd0);
        consume();
        check("t1_idle", 32'(busy), 32'd0);

        // Back-to-back: second pair accepted during first's WAIT.
        send(16'd3, 16'hFFFC);
        tick();
        tick();
        tick();
        send(16'hFFF9, 16'd5);
        check("t2_in_ready_held", 32'(in_ready), 32'd0);
        wait_valid("t2_valid1");
        check("t2_product1", out_product, 32'hFFFFFFF4);
        consume();
        check("t2_no_bubble_start", 32'(mul_start), 32'd1);
        check("t2_no_bubble_data", 32'(mul_data), 32'h0000FFF9);
        check("t2_in_ready_free", 32'(in_ready), 32'd1);
        wait_valid("t2_valid2");
        check("t2_product2", out_product, 32'hFFFFFFDD);

        // Stall for 10 cycles; a third pair lands in the holding register meanwhile.
        held = out_product;
        send(16'd2, 16'd9);
        for (int i = 0; i < 9; i++) tick();
        check("t3_stall_valid", 32'(out_valid), 32'd1);
        check("t3_stall_product", out_product, held);
        check("t3_in_ready_low", 32'(in_ready), 32'd0);
        consume();
        check("t3_next_data", 32'(mul_data), 32'd2);
        wait_valid("t3_valid");
        check("t3_product", out_product, 32'd18);
        consume();

        // Watchdog: done never rises.
        never_done = 1'b1;
        send(16'd5, 16'd5);
        tick();
        tick();
        tick();
        n = 0;
        while (!out_valid && n < 30) begin
            tick();
            n++;
        end
        check("t4_timeout_cycles", 32'(n), 32'd8);
        check("t4_timeout_flag", 32'(out_timeout), 32'd1);
        check("t4_timeout_product", out_product, 32'd0);
        consume();
        never_done = 1'b0;

        // Done stuck high from the previous op: only a new rising edge may capture.
        send(16'd4, 16'd4);
        wait_valid("t5_prev_valid");
        check("t5_prev_product", out_product, 32'd16);
        consume();
        drop_delay = 3;
        send(16'd6, 16'hFFFD);
        tick();
        tick();
        tick();
        check("t5_done_still_high", 32'(mul_done), 32'd1);
        tick();
        check("t5_no_early_capture", 32'(out_valid), 32'd0);
        wait_valid("t5_valid");
        check("t5_product", out_product, 32'hFFFFFFEE);
        check("t5_timeout", 32'(out_timeout), 32'd0);
        consume();
        drop_delay = 1;

        // Reset in WAIT with a pair held.
        send(16'd2, 16'd3);
        tick();
        tick();
        tick();
        send(16'd1, 16'd1);
        rst = 1'b1;
        #1;
        check("t6_rst_start", 32'(mul_start), 32'd0);
        check("t6_rst_valid", 32'(out_valid), 32'd0);
        check("t6_rst_in_ready", 32'(in_ready), 32'd1);
        check("t6_rst_busy", 32'(busy), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        tick();
        check("t6_held_discarded", 32'(busy), 32'd0);
        send(16'hFFF8, 16'hFFF8);
        wait_valid("t6_valid");
        check("t6_product", out_product, 32'd64);
        consume();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
